tcdm_mem_responder: RTL
=======================

# tcdm_mem_responder

Single-port TCDM responder: the memory-side end of the XBAR_TCDM_BUS request/grant/r_valid protocol that the fabric-controller core drives on its L2 data and instruction ports. It accepts at most one word request per cycle, applies a configurable number of wait states before granting, performs byte-enabled writes or reads on a word array, and returns a response after a configurable latency. Out-of-range requests complete with an error response and are counted. It serves as a private L2 bank model in SoC integration and as the responder for FC core-level benches.

## Interface
- BASE_ADDR, 32'h1C00_0000: byte address of word 0.
- NUM_WORDS, 1024: array depth in 32-bit words; power of two, 16..65536.
- WAIT_STATES, 0: cycles `req_i` must be held before `gnt_o`; 0..15.
- RESP_LATENCY, 1: cycles from the grant cycle to `r_valid_o`; 1..4.
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  1  request valid.
- add_i  in  32  byte address; `add_i[1:0]` is ignored.
- wen_i  in  1  0 = write, 1 = read (TCDM polarity).
- wdata_i  in  32  write data.
- be_i  in  4  byte enables; bit n covers `wdata_i[8n+7:8n]`.
- gnt_o  out  1  grant; combinational from `req_i` and the wait counter.
- r_valid_o  out  1  response valid, one cycle per granted request.
- r_rdata_o  out  32  read data.
- r_opc_o  out  1  error flag, qualified by `r_valid_o`.
- err_cnt_o  out  16  count of out-of-range granted requests; saturates at 16'hFFFF.

## Operation
- **Decode.** A request is in range when `BASE_ADDR <= add_i < BASE_ADDR + 4*NUM_WORDS`, using a 33-bit compare so there is no wrap. Word index = `(add_i - BASE_ADDR) >> 2`, truncated to `$clog2(NUM_WORDS)` bits.
- **Wait counter.** `wcnt` is a 4-bit counter.
  - `gnt_o = req_i && (wcnt == WAIT_STATES)`.
  - Each edge, `wcnt` becomes 0 if `!req_i` or `gnt_o`; otherwise it increments.
  - When `WAIT_STATES == 0`, `gnt_o` equals `req_i`.
  - If `req_i` drops before grant, the request is abandoned: no access and no response.
- **Granted write, in range.** At the grant edge, each byte with `be_i[n]=1` is written; the other bytes are unchanged. `be_i = 0` writes nothing but still produces a response. The response has `r_opc_o=0` and `r_rdata_o=32'h0`.
- **Granted read, in range.** The word is sampled at the grant edge and returned with `r_opc_o=0`. `be_i` is ignored for reads.
- **Out of range.** No array access. The response has `r_opc_o=1` and `r_rdata_o=32'hBADA_CCE5`. `err_cnt_o` increments at the grant edge.
- **Response pipeline.** A RESP_LATENCY-deep shift register carries {valid, opc, rdata}. Stage 0 is loaded at the grant edge; the last stage drives the outputs. There is no back-pressure: every granted request yields exactly one response, and responses are returned in grant order.
- **Ordering.** Read-after-write to the same word in consecutive grants returns the new data. A write granted in the same cycle that an older read's response is in flight does not alter that read's data.
- **Reset.**
  - Outputs go to: `gnt_o` follows the combinational rule with `wcnt=0`; `r_valid_o=0`, `r_opc_o=0`, `r_rdata_o=0`, `err_cnt_o=0`.
  - The pipeline is cleared, so in-flight responses are dropped, and `wcnt` is cleared.
  - A grant coincident with `rst_i=1` is suppressed: `gnt_o` is forced to 0 while `rst_i` is high.
  - Array contents are not reset.

## Timing
- The grant is issued in the cycle `req_i` has been high for WAIT_STATES+1 consecutive cycles, counting the first cycle as 1.
- For a request granted in cycle t, `r_valid_o` is high in cycle t+RESP_LATENCY.
- Throughput is one request per cycle when WAIT_STATES=0, and one per WAIT_STATES+1 cycles under continuous `req_i`.
- Back-to-back grants produce back-to-back `r_valid_o` pulses.
- The initiator must hold `add_i`, `wen_i`, `wdata_i` and `be_i` stable while `req_i=1` and the request is not yet granted.

## Test plan
- **Basic write/read.** Defaults. Write 32'hDEADBEEF to 0x1C000010 with be=4'hF, then read 0x1C000010. Expect: `gnt_o` in the same cycle as each `req_i`; `r_valid_o` one cycle later; read returns 32'hDEADBEEF with `r_opc_o=0`.
- **Byte enables.** Write 32'h11223344 to word 5, then write 32'hAABBCCDD with be=4'b0101, then read word 5. Expect 32'h11BB33DD.
- **Wait states and latency.** WAIT_STATES=3, RESP_LATENCY=4, `req_i` high from cycle 10. Expect `gnt_o` only in cycle 13 and `r_valid_o` only in cycle 17. Separately, drop `req_i` at cycle 12: expect no grant and no response.
- **Range errors.** Read 0x1C001000, one past the end with NUM_WORDS=1024, then write 0x1BFFFFFC. Expect `r_opc_o=1` and rdata 32'hBADACCE5 on both responses, word 0 unchanged, and `err_cnt_o=2`.
- **Streaming.** RESP_LATENCY=2. Issue 8 consecutive granted requests alternating write/read to the same word. Expect 8 consecutive `r_valid_o` pulses, with each read returning the immediately preceding write's data.
- **Reset mid-flight.** RESP_LATENCY=3. Grant a read, then assert `rst_i` one cycle later. Expect `r_valid_o` to stay 0 and `err_cnt_o=0`. Then read a previously written word: expect the contents are retained.

Source files
------------

// File: rtl/tcdm_mem_responder.sv
// tcdm_mem_responder: single-port TCDM word memory with wait states,
// byte-enabled writes, range-error responses and a fixed-latency response pipe.
module tcdm_mem_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h1C00_0000,
    parameter int          NUM_WORDS    = 1024,
    parameter int          WAIT_STATES  = 0,
    parameter int          RESP_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        r_valid_o,
    output logic [31:0] r_rdata_o,
    output logic        r_opc_o,
    output logic [15:0] err_cnt_o
);

    localparam int          AW       = $clog2(NUM_WORDS);
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(NUM_WORDS) * 33'd4;
    localparam logic [3:0]  WS       = 4'(WAIT_STATES);
    localparam logic [31:0] ERR_DATA = 32'hBADA_CCE5;

    logic [3:0]    wcnt;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          in_range;
    logic [31:0]   rd_word;
    logic [31:0]   s_data;
    logic          unused_offset;

    logic [31:0] mem [NUM_WORDS];

    logic        pv    [RESP_LATENCY];
    logic        popc  [RESP_LATENCY];
    logic [31:0] pdata [RESP_LATENCY];

    assign offset        = add_i - BASE_ADDR;
    assign idx           = offset[AW+1:2];
    assign unused_offset = ^{offset[31:AW+2], offset[1:0]};
    assign in_range      = ({1'b0, add_i} >= {1'b0, BASE_ADDR})
                        && ({1'b0, add_i} < LIMIT);

    assign gnt_o   = req_i && !rst_i && (wcnt == WS);
    assign rd_word = mem[idx];

    always_comb begin
        s_data = 32'h0;
        if (!in_range)
            s_data = ERR_DATA;
        else if (wen_i)
            s_data = rd_word;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !req_i || gnt_o)
            wcnt <= 4'd0;
        else
            wcnt <= wcnt + 4'd1;
    end

    // Array contents survive reset; gnt_o is already low while rst_i is high.
    always_ff @(posedge clk_i) begin
        if (gnt_o && in_range && !wen_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b])
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RESP_LATENCY; i++) begin
                pv[i]    <= 1'b0;
                popc[i]  <= 1'b0;
                pdata[i] <= 32'h0;
            end
        end else begin
            pv[0]    <= gnt_o;
            popc[0]  <= gnt_o && !in_range;
            pdata[0] <= gnt_o ? s_data : 32'h0;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                pv[i]    <= pv[i-1];
                popc[i]  <= popc[i-1];
                pdata[i] <= pdata[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_cnt_o <= 16'h0;
        else if (gnt_o && !in_range && err_cnt_o != 16'hFFFF)
            err_cnt_o <= err_cnt_o + 16'd1;
    end

    assign r_valid_o = pv[RESP_LATENCY-1];
    assign r_opc_o   = popc[RESP_LATENCY-1];
    assign r_rdata_o = pdata[RESP_LATENCY-1];

endmodule
